// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data-bus responder and its access checker.
// FSM encodings, legal byte-enable codes and the store lane-merge helper.
package data_bus_responder_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WAIT,
        BUS_RESP
    } bus_state_t;

    localparam logic [3:0] BYTEEN_B0 = 4'b0001;
    localparam logic [3:0] BYTEEN_B1 = 4'b0010;
    localparam logic [3:0] BYTEEN_B2 = 4'b0100;
    localparam logic [3:0] BYTEEN_B3 = 4'b1000;
    localparam logic [3:0] BYTEEN_H0 = 4'b0011;
    localparam logic [3:0] BYTEEN_H1 = 4'b1100;
    localparam logic [3:0] BYTEEN_W  = 4'b1111;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_bus_responder_access_checker.sv
// bus_access_checker: word index and legality of a bus access.
// Shared by the data- and instruction-side responders.
module bus_access_checker
    import data_bus_responder_pkg::*;
#(
    parameter int          WORD_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic [31:0]                addr,
    input  logic [3:0]                 byteen,
    output logic [WORD_ADDR_WIDTH-1:0] word_idx,
    output logic                       error
);

    logic [31:0] offset;
    logic        oor;
    logic        misalign;

    // offset wraps mod 2^32, so addresses below BASE_ADDR land out of range
    assign offset   = addr - BASE_ADDR;
    assign oor      = {1'b0, offset} >= (33'd4 << WORD_ADDR_WIDTH);
    assign word_idx = offset[WORD_ADDR_WIDTH+1:2];

    always_comb begin
        misalign = 1'b1;
        case (byteen)
            BYTEEN_B0: misalign = (addr[1:0] != 2'd0);
            BYTEEN_B1: misalign = (addr[1:0] != 2'd1);
            BYTEEN_B2: misalign = (addr[1:0] != 2'd2);
            BYTEEN_B3: misalign = (addr[1:0] != 2'd3);
            BYTEEN_H0: misalign = (addr[1:0] != 2'd0);
            BYTEEN_H1: misalign = (addr[1:0] != 2'd2);
            BYTEEN_W:  misalign = (addr[1:0] != 2'd0);
            default:   misalign = 1'b1;
        endcase
    end

    assign error = oor | misalign;

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: one request at a time, WAIT_STATES wait cycles, internal RAM.
// Define DATA_BUS_WRITE_LOG_EN to print a line for every committed store.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          WORD_ADDR_WIDTH = 10,
    parameter int          WAIT_STATES     = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 1 << WORD_ADDR_WIDTH;
    localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    bus_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic          go_resp;
    logic          accept;

    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;

    logic          acc_wr;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;

    logic [WORD_ADDR_WIDTH-1:0] idx;
    logic                       err;
    logic [31:0]                merged;

    logic [31:0] mem [DEPTH];

`ifdef DATA_BUS_WRITE_LOG_EN
    logic [31:0] pc_q;
    logic [31:0] acc_pc;
    assign acc_pc = (state == BUS_IDLE) ? req_pc : pc_q;
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    assign req_ready = (state == BUS_IDLE);
    assign accept    = req_valid & req_ready;

    // with zero wait states the access uses the live request on the accept edge
    assign acc_wr    = (state == BUS_IDLE) ? req_write  : wr_q;
    assign acc_addr  = (state == BUS_IDLE) ? req_addr   : addr_q;
    assign acc_wdata = (state == BUS_IDLE) ? req_wdata  : wdata_q;
    assign acc_be    = (state == BUS_IDLE) ? req_byteen : be_q;

    bus_access_checker #(
        .WORD_ADDR_WIDTH(WORD_ADDR_WIDTH),
        .BASE_ADDR      (BASE_ADDR)
    ) u_chk (
        .addr    (acc_addr),
        .byteen  (acc_be),
        .word_idx(idx),
        .error   (err)
    );

    assign merged = merge_lanes(mem[idx], acc_wdata, acc_be);

    always_comb begin
        state_n = state;
        go_resp = 1'b0;
        unique case (state)
            BUS_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_n = BUS_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_n = BUS_WAIT;
                    end
                end
            end
            BUS_WAIT: begin
                if (cnt <= CW'(1)) begin
                    state_n = BUS_RESP;
                    go_resp = 1'b1;
                end
            end
            BUS_RESP: begin
                if (resp_ready) state_n = BUS_IDLE;
            end
            default: state_n = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= BUS_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
`ifdef DATA_BUS_WRITE_LOG_EN
            pc_q       <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_byteen;
                cnt     <= CW'(WAIT_STATES);
`ifdef DATA_BUS_WRITE_LOG_EN
                pc_q    <= req_pc;
`endif
            end else if (state == BUS_WAIT) begin
                cnt <= cnt - 1'b1;
            end

            if (go_resp) begin
                resp_valid <= 1'b1;
                resp_error <= err;
                resp_rdata <= (err | acc_wr) ? 32'h0 : mem[idx];
                if (!err && acc_wr) begin
                    mem[idx] <= merged;
`ifdef DATA_BUS_WRITE_LOG_EN
                    $display("@%h: *%h <= %h", acc_pc,
                             {acc_addr[31:2], 2'b00}, merged);
`endif
                end
            end else if (state == BUS_RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= '0;
                resp_error <= 1'b0;
            end
        end
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Memory-side responder for the CPU data bus: accepts one load/store request at a time on a valid/ready handshake.
- Inserts a fixed number of wait states, then performs the access against an internal word-addressed RAM.
- Returns the result on a valid/ready response channel.
- Replaces the zero-latency data memory once the core moves to a stall-capable pipeline.

Parameters:
- WORD_ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
- WAIT_STATES, 2, cycles spent in WAIT between request acceptance and the response; 0 is legal.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4 KiB-aligned.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears state and RAM
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, lanes aligned to the address (byte n in bits 8n+7:8n)
- req_byteen  in  4  lane enables; legal values 4'b0001/0010/0100/1000/0011/1100/1111
- req_pc  in  32  PC of the issuing instruction, for debug only
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  load data, full word with all lanes; 0 for stores and errors
- resp_error  out  1  request was illegal and had no side effect

Behaviour:
- Reset: synchronous, active-high.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
  - FSM returns to IDLE.
  - Wait counter = 0.
  - All RAM words = 0, cleared within the reset cycle.
- Reset mid-transaction aborts it; a pending store is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid && req_ready.
  - On acceptance, latch write, addr, wdata, byteen and pc.
  - Go to WAIT with counter=WAIT_STATES, or go directly to RESP when WAIT_STATES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; on the cycle it reaches 1, transition to RESP.
- Entry into RESP:
  - The RAM access happens on the transition edge into RESP.
  - A store commits only the enabled lanes.
  - A load registers the whole addressed word into resp_rdata.
  - resp_valid rises on the first RESP cycle.
- Latency: accept edge to resp_valid = WAIT_STATES+1 cycles.
- RESP:
  - resp_valid, resp_rdata and resp_error are held stable until resp_valid && resp_ready.
  - On handshake, go to IDLE and clear resp_valid, resp_rdata and resp_error.
  - req_ready=0 throughout; no back-to-back overlap, so minimum throughput is one request per WAIT_STATES+2 cycles.
- Error conditions (resp_error=1, no RAM change, resp_rdata=0):
  - (req_addr - BASE_ADDR) >= 4<<WORD_ADDR_WIDTH (out of range).
  - req_byteen not in the legal set.
  - byteen inconsistent with addr[1:0]: single byte requires byteen=1<<addr[1:0]; halfword requires addr[1]?1100:0011 with addr[0]=0; word requires addr[1:0]=0.
- Word index = (req_addr-BASE_ADDR)[WORD_ADDR_WIDTH+1:2]; the subtraction wraps modulo 2^32.
- req_* inputs are don't-care when req_valid=0 or when not in IDLE.
- resp_ready is ignored outside RESP.

Optional Feature:
- Macro: DATA_BUS_WRITE_LOG_EN.
- Defined:
  - Every committed store prints one line at commit: "@<req_pc 8 hex>: *<word-aligned byte address 8 hex> <= <resulting full RAM word 8 hex>".
  - The word printed is the merged post-write value.
  - Erroring stores print nothing.
- Undefined: no simulation output and no logic difference.

Decomposition:
- Shared constants package (constants include):
  - FSM state encodings BUS_IDLE, BUS_WAIT, BUS_RESP.
  - Legal byte-enable codes BYTEEN_B0..B3, BYTEEN_H0, BYTEEN_H1, BYTEEN_W.
- Sub-module bus_access_checker (combinational): takes addr, byteen, BASE_ADDR and depth; outputs the word index and the error flag. It is shared with the future instruction-side responder.
- The RAM array and FSM stay in the top module.

Test Plan:
- Reset, then word store then load:
  - Store addr=0x10, wdata=0xDEADBEEF, byteen=1111.
  - Load 0x10 → resp_rdata=0xDEADBEEF, resp_error=0.
  - resp_valid rises exactly 3 cycles after acceptance (WAIT_STATES=2).
- Byte merge:
  - Over word 0x11223344 at 0x20, store byte at 0x22 with wdata=0x00AA0000, byteen=0100.
  - Load 0x20 → 0x11AA3344.
  - Log line shows "*00000020 <= 11aa3344".
- Errors:
  - Load 0x1000 (out of range, depth 1024) → resp_error=1, rdata=0.
  - Halfword store at 0x21 with byteen=0011 → resp_error=1, and a subsequent load of 0x20 is unchanged.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles in RESP → resp_valid and rdata stable, req_ready=0.
  - A new req_valid during that time is not accepted; it is accepted on the cycle after the handshake.
- Reset during WAIT of a store to 0x30 → later load of 0x30 returns 0; req_ready=1 on the cycle after reset.
- WAIT_STATES=0 build: resp_valid on the cycle after acceptance; load returns correct data.
